// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline-observation inputs and the pipeline
// control outputs of the hazard/pipeline-control unit.
//   master : pipeline side (drives ID/EX observations, receives controls)
//   slave  : hazard_ctrl side
// Signals:
//   id_rs1_addr/id_rs2_addr [4:0] : source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2       : instruction in ID reads rs1/rs2
//   ex_mem_read, ex_reg_write_en  : ID/EX register MemRead / reg_write_en
//   ex_rd_addr [4:0]              : ID/EX register rd
//   ex_redirect                   : branch taken / jump resolved in EX
//   pc_write_en, if_id_write_en   : PC and IF/ID write enables
//   flush_if_id, flush_id_ex      : load NOP / bubble on next edge
//   stall_active                  : PC/IF-ID frozen this cycle
//   load_stall_count, redirect_count [CNT_W-1:0] : performance counters
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic             ex_reg_write_en;
  logic [4:0]       ex_rd_addr;
  logic             ex_redirect;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             stall_active;
  logic [CNT_W-1:0] load_stall_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_reg_write_en, ex_rd_addr, ex_redirect,
    input  pc_write_en, if_id_write_en, flush_if_id, flush_id_ex,
           stall_active, load_stall_count, redirect_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_reg_write_en, ex_rd_addr, ex_redirect,
    output pc_write_en, if_id_write_en, flush_if_id, flush_id_ex,
           stall_active, load_stall_count, redirect_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use hazard detection and pipeline control.
// Inserts LOAD_STALL_CYCLES bubbles into ID/EX per load-use hazard (PC and
// IF/ID frozen meanwhile) and squashes IF/ID + ID/EX on a redirect from EX.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; forces all control outputs to 0
//   hz  : hazard_ctrl_if.slave (observations in, controls/counters out)
// Parameters:
//   LOAD_STALL_CYCLES : bubbles per load-use hazard, 1..15
//   CNT_W             : performance counter width
// Optional build macro HAZARD_PERF_EN enables the load_stall_count and
// redirect_count counters; without it both read 0 and have no flops.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       lu;
  logic       pc_we, ifid_we, fl_ifid, fl_idex, stall;
  logic       stall_flush, redir_flush;

  assign lu = hz.ex_mem_read & hz.ex_reg_write_en & (hz.ex_rd_addr != 5'd0) &
              ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
               (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // rst gates the decode so every control output reads 0 while it is held.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    fl_ifid     = 1'b0;
    fl_idex     = 1'b0;
    stall       = 1'b0;
    stall_flush = 1'b0;
    redir_flush = 1'b0;
    if (!rst) begin
      if (hz.ex_redirect) begin
        // Redirect wins in either state; any pending bubbles are dropped.
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        fl_ifid     = 1'b1;
        fl_idex     = 1'b1;
        redir_flush = 1'b1;
        state_n     = IDLE;
        cnt_n       = '0;
      end else if (state == STALL || lu) begin
        fl_idex     = 1'b1;
        stall       = 1'b1;
        stall_flush = 1'b1;
        if (state == IDLE) begin
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = STALL;
            cnt_n   = CNT_INIT;
          end
        end else if (cnt == 4'd1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  assign hz.pc_write_en    = pc_we;
  assign hz.if_id_write_en = ifid_we;
  assign hz.flush_if_id    = fl_ifid;
  assign hz.flush_id_ex    = fl_idex;
  assign hz.stall_active   = stall;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] ls_cnt, rd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (stall_flush) ls_cnt <= ls_cnt + 1'b1;
      if (redir_flush) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  assign hz.load_stall_count = ls_cnt;
  assign hz.redirect_count   = rd_cnt;
`else
  logic unused_flush;
  assign unused_flush        = stall_flush ^ redir_flush;
  assign hz.load_stall_count = '0;
  assign hz.redirect_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl. Two instances
// (LOAD_STALL_CYCLES=1 and =3) see identical inputs; each cycle's control
// vector {pc_write_en, if_id_write_en, flush_if_id, flush_id_ex,
// stall_active} is compared against hand-computed values.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] ZERO = 5'b00000;
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] STL  = 5'b00011;
  localparam logic [4:0] RDR  = 5'b11110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) if1 ();
  hazard_ctrl_if #(.CNT_W(CNT_W)) if3 ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .hz(if1));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) dut3 (.clk(clk), .rst(rst), .hz(if3));

  logic [4:0] v1, v3;
  assign v1 = {if1.pc_write_en, if1.if_id_write_en, if1.flush_if_id, if1.flush_id_ex, if1.stall_active};
  assign v3 = {if3.pc_write_en, if3.if_id_write_en, if3.flush_if_id, if3.flush_id_ex, if3.stall_active};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic rw, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic redir);
    if1.ex_mem_read = mr;  if3.ex_mem_read = mr;
    if1.ex_reg_write_en = rw; if3.ex_reg_write_en = rw;
    if1.ex_rd_addr = rd;   if3.ex_rd_addr = rd;
    if1.id_rs1_addr = rs1; if3.id_rs1_addr = rs1;
    if1.id_uses_rs1 = u1;  if3.id_uses_rs1 = u1;
    if1.id_rs2_addr = rs2; if3.id_rs2_addr = rs2;
    if1.id_uses_rs2 = u2;  if3.id_uses_rs2 = u2;
    if1.ex_redirect = redir; if3.ex_redirect = redir;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Load writing x5 in EX, instruction in ID reads x5 via rs1.
  task automatic haz();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
  endtask

  // Check both control vectors mid-cycle, then advance to 1 ns past next edge.
  task automatic step(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    #1;
    check({tag, "/L1"}, 32'(v1), 32'(e1));
    check({tag, "/L3"}, 32'(v3), 32'(e3));
    @(posedge clk);
    #1;
  endtask

  task automatic counts(input string tag, input int ls1, input int ls3, input int rd);
    check({tag, "/ls1"}, if1.load_stall_count, PERF ? 32'(ls1) : 32'd0);
    check({tag, "/ls3"}, if3.load_stall_count, PERF ? 32'(ls3) : 32'd0);
    check({tag, "/rd1"}, if1.redirect_count,   PERF ? 32'(rd)  : 32'd0);
    check({tag, "/rd3"}, if3.redirect_count,   PERF ? 32'(rd)  : 32'd0);
  endtask

  initial begin
    // Reset with a redirect + hazard present: outputs must still be 0.
    drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    #2;
    check("rst/L1", 32'(v1), 32'(ZERO));
    check("rst/L3", 32'(v3), 32'(ZERO));
    check("rst/ls1", if1.load_stall_count, 32'd0);
    check("rst/rd3", if3.redirect_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    step("idle", NORM, NORM);

    // Single load-use hazard: L1 one bubble, L3 three bubbles then IDLE.
    haz();  step("lu_c1", STL, STL);
    idle(); step("lu_c2", NORM, STL);
    step("lu_c3", NORM, STL);
    #1; counts("lu_cnt", 1, 3, 0);
    step("lu_c4", NORM, NORM);

    // Non-hazards: rd=0, rs2 match unused, no MemRead, no reg write.
    drive(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); step("rd0", NORM, NORM);
    drive(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0); step("rs2_unused", NORM, NORM);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0); step("no_mr", NORM, NORM);
    drive(1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0); step("no_rw", NORM, NORM);
    // rs2 match used -> hazard.
    drive(1'b1, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0); step("rs2_lu", STL, STL);
    idle(); step("rs2_c2", NORM, STL);
    step("rs2_c3", NORM, STL);
    step("rs2_c4", NORM, NORM);

    // Redirect beats load-use.
    drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1); step("redir_lu", RDR, RDR);
    idle(); step("redir_after", NORM, NORM);
    // Redirect while L3 sits in STALL abandons remaining bubbles.
    haz(); step("rs_c1", STL, STL);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); step("rs_redir", RDR, RDR);
    idle(); #1; counts("redir_cnt", 3, 7, 2);
    step("rs_after", NORM, NORM);

    // Reset pulsed in the 2nd cycle of a 3-cycle stall.
    haz(); step("mr_c1", STL, STL);
    idle(); rst = 1'b1;
    #1;
    check("mr_rst/L1", 32'(v1), 32'(ZERO));
    check("mr_rst/L3", 32'(v3), 32'(ZERO));
    counts("mr_cnt", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("mr_rel", NORM, NORM);
    haz(); step("mr_h1", STL, STL);
    idle(); step("mr_h2", NORM, STL);
    step("mr_h3", NORM, STL);
    step("mr_h4", NORM, NORM);

    // Back-to-back dependent loads, one normal cycle between.
    haz(); step("bb_c1", STL, STL);
    idle(); step("bb_c2", NORM, STL);
    haz(); step("bb_c3", STL, STL);
    idle(); step("bb_c4", NORM, NORM);

    // Hazard held: L3 re-detects on return to IDLE with no gap cycle.
    haz(); step("hold_c1", STL, STL);
    step("hold_c2", STL, STL);
    step("hold_c3", STL, STL);
    step("hold_c4", STL, STL);
    idle(); step("hold_c5", NORM, STL);
    step("hold_c6", NORM, STL);
    #1; counts("end_cnt", 7, 12, 0);
    step("hold_c7", NORM, NORM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
